// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_updown_counter
// Purpose  : Parametrised loadable up/down counter with a programmable
//            terminal value (legal range 0..limit), wrap or saturate mode,
//            a registered terminal-count pulse and a sticky overflow flag.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH     : counter and data width in bits (>= 2)
//   RESET_VAL : value loaded into count on reset
// Ports
//   clk      in   clock, all state updates on rising edge
//   clr      in   synchronous active-low reset
//   en       in   count enable, one step per cycle
//   load     in   synchronous parallel load of din (priority over en)
//   din      in   parallel load data [WIDTH]
//   up_dn    in   1 = count up, 0 = count down
//   sat_mode in   1 = saturate at boundary, 0 = wrap
//   limit    in   terminal value [WIDTH]
//   ovf_clr  in   clears sticky ovf (a coincident boundary event wins)
//   count    out  current count, registered [WIDTH]
//   tc       out  one-cycle pulse the cycle after a boundary event
//   ovf      out  sticky boundary-event flag
// ============================================================================
module param_updown_counter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             event_w;

  // Next-state logic. Priority: load > en > hold (reset handled in the
  // register process and overrides everything).
  always_comb begin
    count_d = count_q;
    event_w = 1'b0;

    if (load) begin
      count_d = din;
    end else if (en) begin
      if (count_q > limit) begin
        // Count left the legal range (load above limit, or limit lowered):
        // pull it back to the terminal value and flag it as a boundary.
        count_d = limit;
        event_w = 1'b1;
      end else if (up_dn) begin
        if (count_q == limit) begin
          event_w = 1'b1;
          count_d = sat_mode ? limit : C_ZERO;
        end else begin
          count_d = count_q + C_ONE;
        end
      end else begin
        if (count_q == C_ZERO) begin
          event_w = 1'b1;
          count_d = sat_mode ? C_ZERO : limit;
        end else begin
          count_d = count_q - C_ONE;
        end
      end
    end

    tc_d  = event_w;
    // Set has priority over clear so a coincident event is never lost.
    ovf_d = event_w | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_updown_counter
// Purpose  : Self-checking bench for param_updown_counter (WIDTH=8,
//            RESET_VAL=5): directed vector table, a short hand-written
//            sequence, then randomized stimulus against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_param_updown_counter;

  localparam int WIDTH = 8;
  localparam int RVAL  = 5;

  logic             clk = 1'b0;
  logic             clr, en, load, up_dn, sat_mode, ovf_clr;
  logic [WIDTH-1:0] din, limit;
  logic [WIDTH-1:0] count;
  logic             tc, ovf;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_count, m_tc, m_ovf;

  param_updown_counter #(.WIDTH(WIDTH), .RESET_VAL(8'(RVAL))) dut (
    .clk(clk), .clr(clr), .en(en), .load(load), .din(din), .up_dn(up_dn),
    .sat_mode(sat_mode), .limit(limit), .ovf_clr(ovf_clr),
    .count(count), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, load, en;
    logic [7:0] din;
    logic       up, sat;
    logic [7:0] lim;
    logic       oc;
    int         ec, et, eo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic ld, logic e, int d, logic u,
                              logic s, int l, logic oc, int ec, int et, int eo);
    vec_t v;
    v.clr = c; v.load = ld; v.en = e; v.din = 8'(d); v.up = u; v.sat = s;
    v.lim = 8'(l); v.oc = oc; v.ec = ec; v.et = et; v.eo = eo;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: range arithmetic modulo (limit+1), min/max for
  // saturation; computed from the current inputs before the edge.
  task automatic model_next(output int nc, output int nt, output int no);
    int c, l;
    bit evt;
    c = m_count; l = int'(limit); evt = 0;
    if (!clr) begin
      nc = RVAL; nt = 0; no = 0;
    end else if (load) begin
      nc = int'(din); nt = 0; no = (m_ovf != 0 && !ovf_clr) ? 1 : 0;
    end else if (en) begin
      if (c > l) begin
        nc = l; evt = 1;
      end else if (up_dn) begin
        evt = (c == l);
        nc  = sat_mode ? ((c + 1 > l) ? l : c + 1) : (c + 1) % (l + 1);
      end else begin
        evt = (c == 0);
        nc  = sat_mode ? ((c - 1 < 0) ? 0 : c - 1) : (c + l) % (l + 1);
      end
      nt = evt ? 1 : 0;
      no = (evt || (m_ovf != 0 && !ovf_clr)) ? 1 : 0;
    end else begin
      nc = c; nt = 0; no = (m_ovf != 0 && !ovf_clr) ? 1 : 0;
    end
  endtask

  // Advance one clock: model tracks the DUT, outputs sampled #1 after edge.
  task automatic cycle();
    int nc, nt, no;
    model_next(nc, nt, no);
    @(posedge clk);
    #1;
    m_count = nc; m_tc = nt; m_ovf = no;
  endtask

  task automatic drive(logic c, logic ld, logic e, int d, logic u, logic s,
                       int l, logic oc);
    clr = c; load = ld; en = e; din = 8'(d); up_dn = u; sat_mode = s;
    limit = 8'(l); ovf_clr = oc;
  endtask

  initial begin
    clr = 0; load = 0; en = 0; din = '0; up_dn = 1; sat_mode = 0;
    limit = '0; ovf_clr = 0;
    m_count = 0; m_tc = 0; m_ovf = 0;
    @(negedge clk);

    //          clr ld en din up sat lim oc   cnt tc ovf
    // reset overrides load
    vecs.push_back(mk(0, 1, 0,   9, 1, 0,   3, 0,   5, 0, 0));
    vecs.push_back(mk(0, 1, 1,   9, 1, 0,   3, 0,   5, 0, 0));
    vecs.push_back(mk(1, 0, 0,   9, 1, 0,   3, 0,   5, 0, 0));
    // up-wrap, limit 3
    vecs.push_back(mk(1, 1, 0,   0, 1, 0,   3, 0,   0, 0, 0));
    vecs.push_back(mk(1, 0, 1,   0, 1, 0,   3, 0,   1, 0, 0));
    vecs.push_back(mk(1, 0, 1,   0, 1, 0,   3, 0,   2, 0, 0));
    vecs.push_back(mk(1, 0, 1,   0, 1, 0,   3, 0,   3, 0, 0));
    vecs.push_back(mk(1, 0, 1,   0, 1, 0,   3, 0,   0, 1, 1));
    vecs.push_back(mk(1, 0, 1,   0, 1, 0,   3, 0,   1, 0, 1));
    // clear ovf, then down-saturate, limit 10
    vecs.push_back(mk(1, 0, 0,   0, 1, 0,  10, 1,   1, 0, 0));
    vecs.push_back(mk(1, 1, 0,   2, 0, 1,  10, 0,   2, 0, 0));
    vecs.push_back(mk(1, 0, 1,   0, 0, 1,  10, 0,   1, 0, 0));
    vecs.push_back(mk(1, 0, 1,   0, 0, 1,  10, 0,   0, 0, 0));
    vecs.push_back(mk(1, 0, 1,   0, 0, 1,  10, 0,   0, 1, 1));
    vecs.push_back(mk(1, 0, 1,   0, 0, 1,  10, 0,   0, 1, 1));
    // out-of-range after load, then limit lowered below count
    vecs.push_back(mk(1, 1, 0, 200, 1, 0,   7, 0, 200, 0, 1));
    vecs.push_back(mk(1, 0, 1,   0, 1, 0,   7, 0,   7, 1, 1));
    vecs.push_back(mk(1, 0, 0,   0, 1, 0,   7, 1,   7, 0, 0));
    vecs.push_back(mk(1, 1, 0,   5, 1, 0,   7, 0,   5, 0, 0));
    vecs.push_back(mk(1, 0, 1,   0, 1, 0,   7, 0,   6, 0, 0));
    vecs.push_back(mk(1, 0, 1,   0, 1, 0,   4, 0,   4, 1, 1));
    // load beats en; event beats ovf_clr; ovf_clr alone clears
    vecs.push_back(mk(1, 1, 1,   3, 1, 0,   3, 0,   3, 0, 1));
    vecs.push_back(mk(1, 0, 1,   0, 1, 0,   3, 1,   0, 1, 1));
    vecs.push_back(mk(1, 0, 0,   0, 1, 0,   3, 1,   0, 0, 0));
    // mid-run reset, then limit 0
    vecs.push_back(mk(1, 1, 0, 200, 1, 0, 255, 0, 200, 0, 0));
    vecs.push_back(mk(1, 0, 1,   0, 1, 0, 255, 0, 201, 0, 0));
    vecs.push_back(mk(0, 0, 1,   0, 1, 0, 255, 0,   5, 0, 0));
    vecs.push_back(mk(1, 0, 1,   0, 1, 0,   0, 0,   0, 1, 1));
    vecs.push_back(mk(1, 0, 1,   0, 1, 0,   0, 0,   0, 1, 1));
    vecs.push_back(mk(1, 0, 1,   0, 0, 1,   0, 0,   0, 1, 1));
    vecs.push_back(mk(1, 0, 0,   0, 0, 1,   0, 0,   0, 0, 1));
    // full range natural wrap both directions
    vecs.push_back(mk(1, 1, 0, 255, 1, 0, 255, 1, 255, 0, 0));
    vecs.push_back(mk(1, 0, 1,   0, 1, 0, 255, 0,   0, 1, 1));
    vecs.push_back(mk(1, 0, 1,   0, 0, 0, 255, 0, 255, 1, 1));
    vecs.push_back(mk(1, 0, 1,   0, 0, 0, 255, 0, 254, 0, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].load, vecs[i].en, int'(vecs[i].din),
            vecs[i].up, vecs[i].sat, int'(vecs[i].lim), vecs[i].oc);
      cycle();
      chk($sformatf("vec%0d.count", i), int'(count), vecs[i].ec);
      chk($sformatf("vec%0d.tc", i),    int'(tc),    vecs[i].et);
      chk($sformatf("vec%0d.ovf", i),   int'(ovf),   vecs[i].eo);
    end

    // Hand sequence: tc is a single-cycle pulse even when en stays high
    // across a saturating boundary followed by a normal step.
    drive(1, 1, 0, 9, 1, 1, 10, 1); cycle();
    drive(1, 0, 1, 0, 1, 1, 10, 0); cycle();
    chk("seq.count10", int'(count), 10);
    chk("seq.tc_lo",   int'(tc), 0);
    cycle();
    chk("seq.tc_hi",   int'(tc), 1);
    drive(1, 0, 1, 0, 0, 1, 10, 0); cycle();
    chk("seq.count9",  int'(count), 9);
    chk("seq.tc_drop", int'(tc), 0);
    chk("seq.ovf",     int'(ovf), 1);

    // Randomized phase against the reference model.
    drive(0, 0, 0, 0, 1, 0, 0, 0); cycle();
    for (int n = 0; n < 3000; n++) begin
      clr      = ($urandom_range(0, 60) != 0);
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 3) != 0);
      din      = 8'($urandom_range(0, 255));
      up_dn    = 1'($urandom_range(0, 1));
      sat_mode = 1'($urandom_range(0, 1));
      ovf_clr  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0:       limit = 8'd0;
          1:       limit = 8'd255;
          2:       limit = 8'($urandom_range(1, 12));
          default: limit = 8'($urandom_range(0, 255));
        endcase
      end
      cycle();
      chk("rnd.count", int'(count), m_count);
      chk("rnd.tc",    int'(tc),    m_tc);
      chk("rnd.ovf",   int'(ovf),   m_ovf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
